// File: rtl/axi_lite_master_bridge.sv
// Initiator-side AXI4-Lite bridge: turns a single-outstanding req/gnt/rvalid port into
// AXI4-Lite AW/W/B and AR/R transactions, one transaction in flight at a time.
module axi_lite_master_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
  parameter type axi_lite_req_t = struct packed {
    struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                prot;
    } aw;
    logic aw_valid;
    struct packed {
      logic [AXI_DATA_WIDTH-1:0]   data;
      logic [AXI_DATA_WIDTH/8-1:0] strb;
      logic                        last;
    } w;
    logic w_valid;
    logic b_ready;
    struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                prot;
    } ar;
    logic ar_valid;
    logic r_ready;
  },
  parameter type axi_lite_resp_t = struct packed {
    logic aw_ready;
    logic w_ready;
    logic b_valid;
    struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
    } b;
    logic ar_ready;
    logic r_valid;
    struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
    } r;
  }
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output axi_lite_req_t               axi_req_o,
  input  axi_lite_resp_t              axi_resp_i
);

  typedef enum logic [2:0] {StIdle, StWrite, StWriteB, StRead, StReadR} state_e;

  state_e                      r_state, w_state_d;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_be;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic                        r_aw_done, r_w_done, r_rvalid, r_err;
  logic                        w_aw_done_d, w_w_done_d;
  logic                        w_b_fire, w_r_fire, w_grant;

  // Ids are ignored: only one transaction is ever in flight.
  logic w_unused_ids;
  assign w_unused_ids = ^{axi_resp_i.b.id, axi_resp_i.r.id};

  assign w_grant  = gnt_o;
  assign w_b_fire = (r_state == StWriteB) && axi_resp_i.b_valid;
  assign w_r_fire = (r_state == StReadR) && axi_resp_i.r_valid;

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID;
    axi_req_o.aw.addr  = r_addr;
    axi_req_o.ar.id    = AXI_ID;
    axi_req_o.ar.addr  = r_addr;
    axi_req_o.w.data   = r_wdata;
    axi_req_o.w.strb   = r_be;
    axi_req_o.w.last   = 1'b1;
    gnt_o              = 1'b0;
    w_state_d          = r_state;
    w_aw_done_d        = r_aw_done;
    w_w_done_d         = r_w_done;

    unique case (r_state)
      StIdle: begin
        // Gated with reset so a request is never told it was granted while held in reset.
        gnt_o = req_i & rst_ni;
        if (req_i) w_state_d = we_i ? StWrite : StRead;
      end
      StWrite: begin
        axi_req_o.aw_valid = !r_aw_done;
        axi_req_o.w_valid  = !r_w_done;
        w_aw_done_d        = r_aw_done | axi_resp_i.aw_ready;
        w_w_done_d         = r_w_done | axi_resp_i.w_ready;
        if (w_aw_done_d && w_w_done_d) begin
          w_state_d   = StWriteB;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
        end
      end
      StWriteB: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_resp_i.b_valid) w_state_d = StIdle;
      end
      StRead: begin
        axi_req_o.ar_valid = 1'b1;
        if (axi_resp_i.ar_ready) w_state_d = StReadR;
      end
      StReadR: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_resp_i.r_valid) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_aw_done <= w_aw_done_d;
      r_w_done  <= w_w_done_d;
      r_rvalid  <= w_b_fire | w_r_fire;
      if (w_grant) begin
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_be    <= be_i;
      end
      if (w_b_fire) r_err <= (axi_resp_i.b.resp != 2'b00);
      if (w_r_fire) begin
        r_err   <= (axi_resp_i.r.resp != 2'b00);
        r_rdata <= axi_resp_i.r.data;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: a randomizing requester and AXI-Lite slave, checked every
// cycle against a transaction-phase model, plus directed scenarios with literal expectations.
module tb_axi_lite_master_bridge;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 10;
  localparam logic [IW-1:0] ID = 10'h2A;

  typedef struct packed {
    logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] prot;
  } ax_t;
  typedef struct packed {logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last;} w_t;
  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} b_t;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp;} r_t;
  typedef struct packed {
    ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    ax_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic w_ready; logic b_valid; b_t b;
    logic ar_ready; logic r_valid; r_t r;
  } resp_t;
  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW/8-1:0] be;} rq_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, gnt, rvalid, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] be;
  req_t  axi_req;
  resp_t axi_resp;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(ID),
    .axi_lite_req_t(req_t), .axi_lite_resp_t(resp_t)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .axi_req_o(axi_req), .axi_resp_i(axi_resp)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester queue and transaction-phase model: 0 idle, 1 address/data, 2 awaiting response.
  rq_t q[$];
  int ph = 0;
  bit m_wr, m_aw_pend, m_w_pend;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_be;
  bit exp_rvalid = 0, exp_err = 0;
  logic [DW-1:0] exp_rdata = '0;
  bit granted, hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int cyc = 0, g_cyc = 0, rv_cyc = -100, rv_cnt = 0;
  bit rv_err, b2b_hit;
  logic [DW-1:0] rv_rdata;
  logic [AW-1:0] cap_awaddr;
  logic [DW-1:0] cap_wdata;

  // Slave state and knobs.
  int pct = 100, aw_dly = -1, ar_dly = -1, rsp_dly = -1, force_resp = -1;
  bit force_rdata_en = 0;
  logic [DW-1:0] force_rdata = '0;
  bit s_aw_got, s_w_got, s_ar_got;
  int s_bwait, s_bwant, s_rwait, s_rwant;

  function automatic int pick_dly();
    return (rsp_dly < 0) ? int'($urandom_range(3)) : rsp_dly;
  endfunction

  function automatic logic [1:0] pick_resp();
    if (force_resp >= 0) return 2'(force_resp);
    return ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
  endfunction

  task automatic push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] b);
    rq_t r;
    r.we = w; r.addr = a; r.wdata = d; r.be = b;
    q.push_back(r);
  endtask

  task automatic check_and_model();
    bit e_gnt, e_aw, e_w, e_ar, e_b, e_r, n_rvalid;
    cyc++;
    e_gnt = req && (ph == 0);
    e_aw  = (ph == 1) && m_wr && m_aw_pend;
    e_w   = (ph == 1) && m_wr && m_w_pend;
    e_ar  = (ph == 1) && !m_wr;
    e_b   = (ph == 2) && m_wr;
    e_r   = (ph == 2) && !m_wr;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("aw_valid", 64'(axi_req.aw_valid), 64'(e_aw));
    chk("w_valid", 64'(axi_req.w_valid), 64'(e_w));
    chk("ar_valid", 64'(axi_req.ar_valid), 64'(e_ar));
    chk("b_ready", 64'(axi_req.b_ready), 64'(e_b));
    chk("r_ready", 64'(axi_req.r_ready), 64'(e_r));
    if (e_aw) begin
      chk("aw_addr", 64'(axi_req.aw.addr), 64'(m_addr));
      chk("aw_id", 64'(axi_req.aw.id), 64'(ID));
      chk("aw_len", 64'(axi_req.aw.len), 64'(0));
      chk("aw_prot", 64'(axi_req.aw.prot), 64'(0));
    end
    if (e_w) begin
      chk("w_data", 64'(axi_req.w.data), 64'(m_wdata));
      chk("w_strb", 64'(axi_req.w.strb), 64'(m_be));
      chk("w_last", 64'(axi_req.w.last), 64'(1));
    end
    if (e_ar) begin
      chk("ar_addr", 64'(axi_req.ar.addr), 64'(m_addr));
      chk("ar_id", 64'(axi_req.ar.id), 64'(ID));
      chk("ar_len", 64'(axi_req.ar.len), 64'(0));
      chk("ar_prot", 64'(axi_req.ar.prot), 64'(0));
    end
    chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
    if (exp_rvalid) chk("err", 64'(err), 64'(exp_err));
    chk("rdata", 64'(rdata), 64'(exp_rdata));
    if (axi_req.aw_valid === 1'b1) cap_awaddr = axi_req.aw.addr;
    if (axi_req.w_valid === 1'b1) cap_wdata = axi_req.w.data;
    if (rvalid === 1'b1) begin
      rv_cyc = cyc; rv_err = err; rv_rdata = rdata; rv_cnt++;
    end
    if (e_gnt && cyc == rv_cyc) b2b_hit = 1;

    hs_aw = e_aw && axi_resp.aw_ready;
    hs_w  = e_w && axi_resp.w_ready;
    hs_ar = e_ar && axi_resp.ar_ready;
    hs_b  = e_b && axi_resp.b_valid;
    hs_r  = e_r && axi_resp.r_valid;
    granted = e_gnt;
    n_rvalid = 0;
    case (ph)
      0: if (e_gnt) begin
        m_wr = we; m_addr = addr; m_wdata = wdata; m_be = be;
        m_aw_pend = 1; m_w_pend = 1; ph = 1; g_cyc = cyc;
      end
      1: if (m_wr) begin
        if (hs_aw) m_aw_pend = 0;
        if (hs_w) m_w_pend = 0;
        if (!m_aw_pend && !m_w_pend) ph = 2;
      end else if (hs_ar) ph = 2;
      default: if (hs_b) begin
        n_rvalid = 1; exp_err = (axi_resp.b.resp != 2'b00); ph = 0;
      end else if (hs_r) begin
        n_rvalid = 1; exp_err = (axi_resp.r.resp != 2'b00); exp_rdata = axi_resp.r.data; ph = 0;
      end
    endcase
    exp_rvalid = n_rvalid;
  endtask

  task automatic drive();
    if (granted) void'(q.pop_front());
    granted = 0;
    if (q.size() > 0) begin
      req = 1; we = q[0].we; addr = q[0].addr; wdata = q[0].wdata; be = q[0].be;
    end else begin
      req = 0;
    end
    axi_resp.aw_ready = (aw_dly >= 0) ? (cyc + 1 - g_cyc >= aw_dly) : ($urandom_range(99) < pct);
    axi_resp.ar_ready = (ar_dly >= 0) ? (cyc + 1 - g_cyc >= ar_dly) : ($urandom_range(99) < pct);
    axi_resp.w_ready  = ($urandom_range(99) < pct);
    if (hs_b) axi_resp.b_valid = 0;
    if (hs_aw) s_aw_got = 1;
    if (hs_w) s_w_got = 1;
    if ((hs_aw || hs_w) && s_aw_got && s_w_got) begin s_bwait = 0; s_bwant = pick_dly(); end
    if (!axi_resp.b_valid && s_aw_got && s_w_got) begin
      if (s_bwait >= s_bwant) begin
        axi_resp.b_valid = 1; axi_resp.b.resp = pick_resp(); axi_resp.b.id = IW'($urandom);
        s_aw_got = 0; s_w_got = 0;
      end else s_bwait++;
    end
    if (hs_r) axi_resp.r_valid = 0;
    if (hs_ar) begin s_ar_got = 1; s_rwait = 0; s_rwant = pick_dly(); end
    if (!axi_resp.r_valid && s_ar_got) begin
      if (s_rwait >= s_rwant) begin
        axi_resp.r_valid = 1; axi_resp.r.resp = pick_resp(); axi_resp.r.id = IW'($urandom);
        axi_resp.r.data = force_rdata_en ? force_rdata : {$urandom, $urandom};
        s_ar_got = 0;
      end else s_rwait++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      cycle();
      done = (q.size() == 0) && (ph == 0) && !exp_rvalid && !req;
    end
    if (!done) chk("timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 0; req = 0; we = 0; addr = '0; wdata = '0; be = '0; axi_resp = '0;
    #12;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'(0));
    chk("rst_readies", 64'({axi_req.b_ready, axi_req.r_ready}), 64'(0));
    @(posedge clk); #1 rst_n = 1;

    // Zero-wait write.
    rsp_dly = 0; force_resp = 0; n0 = rv_cnt;
    push(1, 64'h0200_4000, 64'h1122_3344_5566_7788, 8'hFF);
    run_until_idle(50);
    chk("wr_latency", 64'(rv_cyc - g_cyc), 64'(3));
    chk("wr_err", 64'(rv_err), 64'(0));
    chk("wr_awaddr", 64'(cap_awaddr), 64'h0200_4000);
    chk("wr_wdata", 64'(cap_wdata), 64'h1122_3344_5566_7788);
    chk("wr_resp_count", 64'(rv_cnt - n0), 64'(1));

    // W accepted at once, AW held off until cycle 4.
    aw_dly = 4; n0 = rv_cnt;
    push(1, 64'h0000_1000, 64'hA5A5_0000_FFFF_0001, 8'h0F);
    run_until_idle(50);
    chk("skew_latency", 64'(rv_cyc - g_cyc), 64'(6));
    chk("skew_resp_count", 64'(rv_cnt - n0), 64'(1));
    aw_dly = -1;

    // Read with AR and R backpressure.
    ar_dly = 3; rsp_dly = 1; force_rdata_en = 1; force_rdata = 64'hDEAD_BEEF;
    push(0, 64'hBFF8, '0, '0);
    run_until_idle(50);
    chk("rd_latency", 64'(rv_cyc - g_cyc), 64'(6));
    chk("rd_rdata", 64'(rv_rdata), 64'hDEAD_BEEF);
    chk("rd_err", 64'(rv_err), 64'(0));
    repeat (3) cycle();
    chk("rd_hold", 64'(rdata), 64'hDEAD_BEEF);
    ar_dly = -1; rsp_dly = 0; force_rdata_en = 0;

    // Error responses.
    force_resp = 2; push(0, 64'h40, '0, '0); run_until_idle(50);
    chk("rd_slverr", 64'(rv_err), 64'(1));
    force_resp = 3; push(1, 64'h48, 64'h1, 8'h01); run_until_idle(50);
    chk("wr_decerr", 64'(rv_err), 64'(1));
    force_resp = 0;

    // Back-to-back write then read.
    b2b_hit = 0;
    push(1, 64'h100, 64'hCAFE, 8'h03);
    push(0, 64'h208, '0, '0);
    run_until_idle(50);
    chk("b2b_grant_on_rvalid", 64'(b2b_hit), 64'(1));

    // Reset in the middle of a write.
    pct = 0; rsp_dly = -1;
    push(1, 64'h300, 64'h77, 8'hFF);
    for (int i = 0; i < 20 && ph != 1; i++) cycle();
    cycle();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_aw_valid", 64'(axi_req.aw_valid), 64'(0));
    chk("mid_rst_w_valid", 64'(axi_req.w_valid), 64'(0));
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    chk("mid_rst_rvalid", 64'(rvalid), 64'(0));
    q.delete(); req = 0; axi_resp = '0; granted = 0;
    ph = 0; exp_rvalid = 0; exp_rdata = '0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rvalid_hold", 64'(rvalid), 64'(0));
    chk("mid_rst_rdata", 64'(rdata), 64'(0));
    @(posedge clk); #1 rst_n = 1;
    pct = 100; n0 = rv_cnt;
    push(0, 64'h0200_BFF8, '0, '0);
    run_until_idle(50);
    chk("post_rst_read", 64'(rv_cnt - n0), 64'(1));

    // Randomized traffic.
    pct = 60; rsp_dly = -1; force_resp = -1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0 && q.size() < 3)
        push(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
      cycle();
    end
    run_until_idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
